// File: rtl/l2_arb_pkg.sv
// Shared state/op types and limits for the L2 port arbiter.
package l2_arb_pkg;
    localparam int MAX_CORES = 8;
    localparam int ADDR_W    = 15;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first pending requester at or after ptr, wrapping.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);
    int               c;
    logic [IDX_W-1:0] c_idx;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        c         = 0;
        c_idx     = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            c_idx = IDX_W'(c);
            if (!any_valid && pending[c_idx]) begin
                any_valid    = 1'b1;
                idx          = c_idx;
                grant[c_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin sharing of the single L2 L1-side port among N_CORES L1 caches.
// Define L2_ARB_PERF_EN to add per-core saturating grant / wait-cycle counters.
module l2_port_arbiter #(
    parameter int N_CORES = 4,
    parameter int n       = 32,
    parameter int ADDR_W  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_read_request,
    input  logic [N_CORES-1:0]        core_write_request,
    input  logic [N_CORES*ADDR_W-1:0] core_word_address,
    input  logic [N_CORES*n-1:0]      core_wdata,
    output logic [n-1:0]              core_rdata,
    output logic [N_CORES-1:0]        core_done,
    output logic [N_CORES-1:0]        core_flush,
    output logic [ADDR_W-1:0]         L1_word_address,
    output logic [n-1:0]              L1_wdata,
    output logic                      L1_read_request,
    output logic                      L1_write_request,
    input  logic [n-1:0]              L1_rdata,
    input  logic                      L2_busy,
    input  logic                      flush
);
    import l2_arb_pkg::*;

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    arb_state_t                     state, state_next;
    op_t                            op;
    logic [N_CORES-1:0]             pending, pick_grant, winner_oh;
    logic [IDX_W-1:0]               pick_idx, rr_ptr;
    logic                           pick_valid, do_grant, do_done;
    logic [N_CORES-1:0][ADDR_W-1:0] addr_v;
    logic [N_CORES-1:0][n-1:0]      wdata_v;

    assign pending = core_read_request | core_write_request;
    assign addr_v  = core_word_address;
    assign wdata_v = core_wdata;

    rr_priority_picker #(.N(N_CORES), .IDX_W(IDX_W)) u_pick (
        .pending   (pending),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // No grant in the done cycle: the finished core still holds its request then.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && pick_valid && core_done == '0) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (!L2_busy) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr           <= '0;
            winner_oh        <= '0;
            op               <= OP_RD;
            L1_word_address  <= '0;
            L1_wdata         <= '0;
            L1_read_request  <= 1'b0;
            L1_write_request <= 1'b0;
            core_rdata       <= '0;
            core_done        <= '0;
            core_flush       <= '0;
        end else begin
            core_flush <= {N_CORES{flush}};
            core_done  <= '0;
            if (do_grant) begin
                // A core raising both read and write is served as a write.
                winner_oh        <= pick_grant;
                op               <= core_write_request[pick_idx] ? OP_WR : OP_RD;
                L1_word_address  <= addr_v[pick_idx];
                L1_wdata         <= wdata_v[pick_idx];
                L1_write_request <= core_write_request[pick_idx];
                L1_read_request  <= ~core_write_request[pick_idx];
                rr_ptr           <= (int'(pick_idx) == N_CORES - 1) ? '0 : pick_idx + 1'b1;
            end
            if (do_done) begin
                L1_read_request  <= 1'b0;
                L1_write_request <= 1'b0;
                core_done        <= winner_oh;
                if (op == OP_RD) core_rdata <= L1_rdata;
            end
        end
    end

`ifdef L2_ARB_PERF_EN
    logic [15:0] grant_count [N_CORES];
    logic [15:0] wait_count  [N_CORES];

    // The winner's own held request is not counted as waiting.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (reset) begin
                grant_count[i] <= '0;
                wait_count[i]  <= '0;
            end else begin
                if (do_grant && pick_grant[i] && grant_count[i] != 16'hFFFF)
                    grant_count[i] <= grant_count[i] + 16'd1;
                if (pending[i] && !(do_grant && pick_grant[i]) && !(state != IDLE && winner_oh[i])
                    && !core_done[i] && wait_count[i] != 16'hFFFF)
                    wait_count[i] <= wait_count[i] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_l2_port_arbiter;
    localparam int NC = 4;
    localparam int W  = 32;
    localparam int AW = 15;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NC-1:0]         rd_q = '0, wr_q = '0;
    logic [NC-1:0][AW-1:0] addr_q = '0;
    logic [NC-1:0][W-1:0]  wd_q = '0;
    logic [W-1:0]          core_rdata, L1_wdata;
    logic [W-1:0]          L1_rdata = '0;
    logic [NC-1:0]         core_done, core_flush;
    logic [AW-1:0]         L1_word_address;
    logic                  L1_read_request, L1_write_request;
    logic                  L2_busy = 1'b0, flush = 1'b0;
    int                    n_tests = 0, n_fail = 0;

    l2_port_arbiter #(.N_CORES(NC), .n(W), .ADDR_W(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .core_read_request  (rd_q),
        .core_write_request (wr_q),
        .core_word_address  (addr_q),
        .core_wdata         (wd_q),
        .core_rdata         (core_rdata),
        .core_done          (core_done),
        .core_flush         (core_flush),
        .L1_word_address    (L1_word_address),
        .L1_wdata           (L1_wdata),
        .L1_read_request    (L1_read_request),
        .L1_write_request   (L1_write_request),
        .L1_rdata           (L1_rdata),
        .L2_busy            (L2_busy),
        .flush              (flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rd_q = '0; wr_q = '0; L2_busy = 1'b0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_q = 4'b1011; wr_q = 4'b0100; flush = 1'b1; L2_busy = 1'b1;
        L1_rdata = 32'hDEADBEEF; addr_q[0] = 15'h7FFF; wd_q[0] = 32'hFFFFFFFF;
        tick(); tick();
        n_tests++;
        if ({L1_read_request, L1_write_request} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req: got %b expected 00", {L1_read_request, L1_write_request});
        end
        n_tests++;
        if ({core_done, core_flush} !== 8'h00) begin
            n_fail++; $display("FAIL reset_done_flush: got %h expected 00", {core_done, core_flush});
        end
        n_tests++;
        if ({core_rdata, L1_wdata, L1_word_address} !== '0) begin
            n_fail++; $display("FAIL reset_data: rdata=%h wdata=%h addr=%h expected 0", core_rdata, L1_wdata, L1_word_address);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        logic [W-1:0] rv;
        do_reset();
        rv = $urandom; L1_rdata = rv;
        addr_q[1] = 15'd1000; rd_q[1] = 1'b1;
        tick();
        n_tests++;
        if (L1_read_request !== 1'b1 || L1_write_request !== 1'b0 || L1_word_address !== 15'd1000 || core_done !== 4'b0) begin
            n_fail++; $display("FAIL rd_issue: rd=%b wr=%b addr=%0d done=%b expected 1 0 1000 0000",
                               L1_read_request, L1_write_request, L1_word_address, core_done);
        end
        tick();
        n_tests++;
        if (L1_read_request !== 1'b1 || core_done !== 4'b0) begin
            n_fail++; $display("FAIL rd_wait: rd=%b done=%b expected 1 0000", L1_read_request, core_done);
        end
        tick();
        n_tests++;
        if (core_done !== 4'b0010 || core_rdata !== rv || L1_read_request !== 1'b0) begin
            n_fail++; $display("FAIL rd_done: done=%b rdata=%h rd=%b expected 0010 %h 0", core_done, core_rdata, L1_read_request, rv);
        end
        rd_q[1] = 1'b0;
        tick();
    endtask

    task automatic test_rr_order();
        int order [4];
        int cyc;
        order = '{0, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NC; i++) begin
            if (i != 1) begin
                wr_q[i] = 1'b1; addr_q[i] = AW'(100 + i); wd_q[i] = $urandom;
            end
        end
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (L1_write_request !== 1'b1 && cyc < 20) begin tick(); cyc++; end
            n_tests++;
            if (L1_write_request !== 1'b1 || L1_wdata !== wd_q[order[k]] || L1_word_address !== addr_q[order[k]]) begin
                n_fail++; $display("FAIL rr_issue_%0d: wr=%b wdata=%h addr=%h expected 1 %h %h (core %0d)",
                                   k, L1_write_request, L1_wdata, L1_word_address, wd_q[order[k]], addr_q[order[k]], order[k]);
            end
            cyc = 0;
            while (core_done === 4'b0 && cyc < 20) begin tick(); cyc++; end
            n_tests++;
            if (core_done !== 4'(1 << order[k])) begin
                n_fail++; $display("FAIL rr_done_%0d: got %b expected %b", k, core_done, 4'(1 << order[k]));
            end
            wr_q[order[k]] = 1'b0;
            tick();
            if (k == 0) begin
                wr_q[0] = 1'b1; addr_q[0] = 15'd200; wd_q[0] = $urandom;
            end
        end
`ifdef L2_ARB_PERF_EN
        begin
            int expg [4];
            expg = '{2, 0, 1, 1};
            for (int i = 0; i < NC; i++) begin
                n_tests++;
                if (dut.grant_count[i] !== 16'(expg[i])) begin
                    n_fail++; $display("FAIL perf_grant_%0d: got %0d expected %0d", i, dut.grant_count[i], expg[i]);
                end
            end
            for (int i = 2; i < NC; i++) begin
                n_tests++;
                if (dut.wait_count[i] === 16'd0) begin
                    n_fail++; $display("FAIL perf_wait_%0d: got 0 expected nonzero", i);
                end
            end
        end
`endif
    endtask

    task automatic test_miss_hold();
        bit held_ok, early_done;
        int cyc;
        do_reset();
        wr_q[0] = 1'b1; addr_q[0] = 15'h1234; wd_q[0] = $urandom;
        tick();
        n_tests++;
        if (L1_write_request !== 1'b1) begin
            n_fail++; $display("FAIL miss_issue: wr=%b expected 1", L1_write_request);
        end
        L2_busy = 1'b1;
        held_ok = 1'b1; early_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin rd_q[1] = 1'b1; addr_q[1] = 15'h0777; end
            tick();
            if (L1_write_request !== 1'b1) held_ok = 1'b0;
            if (core_done !== 4'b0) early_done = 1'b1;
        end
        n_tests++;
        if (!held_ok) begin n_fail++; $display("FAIL miss_held: got request dropped expected held"); end
        n_tests++;
        if (early_done) begin n_fail++; $display("FAIL miss_early_done: got done during busy expected none"); end
        L2_busy = 1'b0;
        tick();
        n_tests++;
        if (core_done !== 4'b0001) begin n_fail++; $display("FAIL miss_done: got %b expected 0001", core_done); end
        wr_q[0] = 1'b0;
        tick();
        n_tests++;
        if (L1_read_request !== 1'b0) begin n_fail++; $display("FAIL miss_gap: got rd=%b expected 0", L1_read_request); end
        tick();
        n_tests++;
        if (L1_read_request !== 1'b1 || L1_word_address !== 15'h0777) begin
            n_fail++; $display("FAIL miss_next: rd=%b addr=%h expected 1 0777", L1_read_request, L1_word_address);
        end
        cyc = 0;
        while (core_done === 4'b0 && cyc < 20) begin tick(); cyc++; end
        n_tests++;
        if (core_done !== 4'b0010) begin n_fail++; $display("FAIL miss_next_done: got %b expected 0010", core_done); end
        rd_q[1] = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int cyc;
        do_reset();
        rd_q[2] = 1'b1; addr_q[2] = 15'h0222; flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (core_flush !== 4'hF || L1_read_request !== 1'b0) begin
                n_fail++; $display("FAIL flush_on_%0d: flush=%h rd=%b expected F 0", c, core_flush, L1_read_request);
            end
        end
        flush = 1'b0;
        tick();
        n_tests++;
        if (core_flush !== 4'h0 || L1_read_request !== 1'b1 || L1_word_address !== 15'h0222) begin
            n_fail++; $display("FAIL flush_off: flush=%h rd=%b addr=%h expected 0 1 0222", core_flush, L1_read_request, L1_word_address);
        end
        cyc = 0;
        while (core_done === 4'b0 && cyc < 20) begin tick(); cyc++; end
        n_tests++;
        if (core_done !== 4'b0100) begin n_fail++; $display("FAIL flush_done: got %b expected 0100", core_done); end
        rd_q[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        int cyc;
        do_reset();
        rd_q[1] = 1'b1; addr_q[1] = 15'h0111; L2_busy = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({L1_read_request, L1_write_request, core_done, core_flush} !== '0 || {L1_word_address, L1_wdata, core_rdata} !== '0) begin
            n_fail++; $display("FAIL rst_wait_outputs: req=%b done=%b flush=%b addr=%h expected all 0",
                               {L1_read_request, L1_write_request}, core_done, core_flush, L1_word_address);
        end
        reset = 1'b0; L2_busy = 1'b0;
        rd_q[2] = 1'b1; addr_q[2] = 15'h0222;
        tick();
        n_tests++;
        if (L1_read_request !== 1'b1 || L1_word_address !== 15'h0111) begin
            n_fail++; $display("FAIL rst_wait_ptr: rd=%b addr=%h expected 1 0111", L1_read_request, L1_word_address);
        end
        for (int t = 0; t < 2; t++) begin
            cyc = 0;
            while (core_done === 4'b0 && cyc < 20) begin tick(); cyc++; end
            n_tests++;
            if (core_done !== (t == 0 ? 4'b0010 : 4'b0100)) begin
                n_fail++; $display("FAIL rst_wait_done_%0d: got %b", t, core_done);
            end
            rd_q = rd_q & ~core_done;
            tick();
        end
    endtask

    task automatic test_random(input int ncyc);
        int           ptr, win, issue_s, miss_m, done_at, op_sel;
        bit           in_flight, grant_next, done_now, flush_prev, e_wr, found;
        logic [NC-1:0] quiet, pend;
        logic [W-1:0]  rdata_prev, exp_rdata, e_wd;
        logic [AW-1:0] e_addr;
        do_reset();
        ptr = 0; win = 0; issue_s = 0; miss_m = 0; done_at = 0; op_sel = 0;
        in_flight = 0; grant_next = 0; flush_prev = 0; e_wr = 0; found = 0;
        quiet = '0; exp_rdata = '0; rdata_prev = '0; L1_rdata = '0; e_wd = '0; e_addr = '0;
        for (int s = 1; s <= ncyc; s++) begin
            tick();
            done_now = 0;
            n_tests++;
            if (core_flush !== {NC{flush_prev}}) begin
                n_fail++; $display("FAIL rnd_flush@%0d: got %h expected %h", s, core_flush, {NC{flush_prev}});
            end
            if (grant_next) begin
                n_tests++;
                if (L1_write_request !== e_wr || L1_read_request !== !e_wr || L1_word_address !== e_addr
                    || (e_wr && L1_wdata !== e_wd) || core_done !== 4'b0) begin
                    n_fail++; $display("FAIL rnd_issue@%0d: core %0d rd=%b wr=%b addr=%h wdata=%h expected wr=%b addr=%h wdata=%h",
                                       s, win, L1_read_request, L1_write_request, L1_word_address, L1_wdata, e_wr, e_addr, e_wd);
                end
                in_flight = 1; issue_s = s; miss_m = $urandom_range(0, 6);
                done_at = s + 2 + miss_m; ptr = (win + 1) % NC;
            end else if (in_flight) begin
                if (s == done_at) begin
                    n_tests++;
                    if (core_done !== 4'(1 << win) || L1_read_request !== 1'b0 || L1_write_request !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_done@%0d: done=%b req=%b%b expected %b 00",
                                           s, core_done, L1_read_request, L1_write_request, 4'(1 << win));
                    end
                    if (!e_wr) exp_rdata = rdata_prev;
                    in_flight = 0; done_now = 1;
                    rd_q[win] = 1'b0; wr_q[win] = 1'b0; quiet[win] = 1'b0;
                end else begin
                    n_tests++;
                    if (core_done !== 4'b0 || L1_write_request !== e_wr || L1_read_request !== !e_wr) begin
                        n_fail++; $display("FAIL rnd_hold@%0d: done=%b rd=%b wr=%b expected 0000 wr=%b", s, core_done,
                                           L1_read_request, L1_write_request, e_wr);
                    end
                end
            end else begin
                n_tests++;
                if (core_done !== 4'b0 || L1_read_request !== 1'b0 || L1_write_request !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_idle@%0d: done=%b rd=%b wr=%b expected all 0", s, core_done,
                                       L1_read_request, L1_write_request);
                end
            end
            n_tests++;
            if (core_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rnd_rdata@%0d: got %h expected %h", s, core_rdata, exp_rdata);
            end

            L2_busy    = in_flight && (s >= issue_s + 1) && (s <= issue_s + miss_m);
            rdata_prev = $urandom;
            L1_rdata   = rdata_prev;
            for (int i = 0; i < NC; i++) begin
                if (in_flight && i == win && (rd_q[i] | wr_q[i]) && $urandom_range(0, 15) == 0) begin
                    rd_q[i] = 1'b0; wr_q[i] = 1'b0; quiet[i] = 1'b1;
                end else if (!(rd_q[i] | wr_q[i]) && !quiet[i] && !(done_now && i == win)
                             && $urandom_range(0, 3) == 0) begin
                    op_sel = $urandom_range(0, 2);
                    rd_q[i] = (op_sel != 1); wr_q[i] = (op_sel != 0);
                    addr_q[i] = AW'($urandom); wd_q[i] = $urandom;
                end
            end
            flush      = ($urandom_range(0, 9) == 0);
            flush_prev = flush;
            pend       = rd_q | wr_q;
            grant_next = !in_flight && !done_now && pend != '0 && !flush;
            if (grant_next) begin
                found = 0;
                for (int k = 0; k < NC; k++) begin
                    if (!found && pend[(ptr + k) % NC]) begin
                        found = 1; win = (ptr + k) % NC;
                    end
                end
                e_wr = wr_q[win]; e_addr = addr_q[win]; e_wd = wd_q[win];
            end
        end
        rd_q = '0; wr_q = '0; flush = 1'b0; L2_busy = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_order();
        test_miss_hold();
        test_flush();
        test_reset_in_wait();
        test_random(800);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
